// File: rtl/reg_bank_wr_pkg.sv
// Shared register-file constants for the multicycle MIPS datapath.
// The write-register mux uses the same register indices.
package reg_bank_wr_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int DATA_W_DEF  = 32;
  localparam int SP_INIT_DEF = 227;
endpackage

// File: rtl/reg_bank_wr_rdport.sv
// One registered read port. Index 0 always reads as zero, and the port can
// optionally forward a write to the same index that happens in this cycle.
module reg_bank_wr_rdport
  import reg_bank_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rd_reg,
  input  logic [DATA_W-1:0] rd_val,
  input  logic              wr_en,
  input  logic [4:0]        wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic              wr_hit;
  logic [DATA_W-1:0] rd_data_p0;

  assign wr_hit = wr_en && (wr_reg == rd_reg) && (wr_reg != REG_ZERO);

  always_comb begin
    rd_data_p0 = rd_val;
    if (rd_reg == REG_ZERO)
      rd_data_p0 = '0;
    else if (BYPASS && wr_hit)
      rd_data_p0 = wr_data;
  end

  // p0 -> p1: registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_data <= '0;
    else
      rd_data <= rd_data_p0;
  end

endmodule

// File: rtl/reg_bank_wr.sv
// 32 x DATA_W general-purpose register bank: one write port, two registered
// read ports, write acknowledge pulse and a committed-write counter.
module reg_bank_wr
  import reg_bank_wr_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SP_INIT = SP_INIT_DEF,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_reg1,
  input  logic [4:0]        rd_reg2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wr_ack,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs [32];
  logic              vld_p0;

  // Writes to r0 are discarded entirely: no store, no ack, no count.
  assign vld_p0 = wr_en && (wr_reg != REG_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (5'(i) == REG_SP) ? DATA_W'(SP_INIT) : '0;
    end else if (vld_p0) begin
      regs[wr_reg] <= wr_data;
    end
  end

  // p0 -> p1: write acknowledge and commit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ack   <= 1'b0;
      wr_count <= '0;
    end else begin
      wr_ack <= vld_p0;
      if (vld_p0)
        wr_count <= wr_count + 16'd1;
    end
  end

  reg_bank_wr_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rdport1 (
    .clk     (clk),
    .reset   (reset),
    .rd_reg  (rd_reg1),
    .rd_val  (regs[rd_reg1]),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .rd_data (rd_data1)
  );

  reg_bank_wr_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rdport2 (
    .clk     (clk),
    .reset   (reset),
    .rd_reg  (rd_reg2),
    .rd_val  (regs[rd_reg2]),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .rd_data (rd_data2)
  );

endmodule
